axi_master_arbiter: RTL and testbench



---
 rtl/ysyx_25040129_axi_pkg.sv | 33 +++
 rtl/axi_rr_arbiter.sv | 54 +++++
 rtl/axi_master_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_axi_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_axi_pkg
//
// Purpose: definitions shared by the AXI4 master front-end and its grant unit.
//   - axi_state_e : transaction FSM states (IDLE, AR, R, AW_W, B)
//   - owner_e     : which requester owns the current transaction
//   - GNT_IFU/GNT_LSU : bit positions inside the one-hot grant vector
//   - SIZE_4B, BURST_INCR, RESP_OKAY : fixed AXI encodings
// Ports: none (package).
// ----------------------------------------------------------------------------
package ysyx_25040129_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } axi_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int GNT_IFU = 0;
    localparam int GNT_LSU = 1;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_rr_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rr_arbiter
//
// Purpose: 2-way grant unit for the AXI master front-end. Produces a one-hot
// grant while enabled (the parent enables it only in IDLE).
//   YSYX_25040129_AXI_RR_EN defined   : round-robin, a tie goes to the
//                                       requester that was not granted last.
//   YSYX_25040129_AXI_RR_EN undefined : fixed priority, LSU beats IFU.
//
// Ports:
//   en_i         in  1 : grant enable
//   req_ifu_i    in  1 : IFU request
//   req_lsu_i    in  1 : LSU request
//   last_grant_i in  1 : requester granted most recently (owner_e)
//   grant_o      out 2 : one-hot grant, bit GNT_IFU / GNT_LSU
// ----------------------------------------------------------------------------
module axi_rr_arbiter
    import ysyx_25040129_axi_pkg::*;
(
    input  logic       en_i,
    input  logic       req_ifu_i,
    input  logic       req_lsu_i,
    input  owner_e     last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (req_ifu_i && req_lsu_i) begin
`ifdef YSYX_25040129_AXI_RR_EN
                if (last_grant_i == OWN_IFU) begin
                    grant_o[GNT_LSU] = 1'b1;
                end else begin
                    grant_o[GNT_IFU] = 1'b1;
                end
`else
                grant_o[GNT_LSU] = 1'b1;
`endif
            end else if (req_lsu_i) begin
                grant_o[GNT_LSU] = 1'b1;
            end else if (req_ifu_i) begin
                grant_o[GNT_IFU] = 1'b1;
            end
        end
    end

`ifndef YSYX_25040129_AXI_RR_EN
    // Fixed priority has no use for the history bit.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/axi_master_arbiter.sv
// ----------------------------------------------------------------------------
// axi_master_arbiter
//
// Purpose: two-requester AXI4 master front-end. Grants IFU or LSU one at a
// time, issues a BURST_LEN-beat INCR read for IFU line fills or a single-beat
// read/write for the LSU, and routes the read beats / write response back to
// the owner. Exactly one AXI transaction is outstanding at any time.
// Build option: YSYX_25040129_AXI_RR_EN selects round-robin arbitration
// (default: fixed priority, LSU first).
//
// Ports:
//   clock, reset (async, active-high)
//   ifu_req_{valid,ready,addr}, ifu_resp_{valid,data,last}
//   lsu_req_{valid,ready,wen,addr,wdata,wstrb}, lsu_resp_{valid,data,err}
//   io_master_aw{valid,ready,addr,id,len,size,burst}
//   io_master_w{valid,ready,data,strb,last}
//   io_master_b{valid,ready,resp}
//   io_master_ar{valid,ready,addr,id,len,size,burst}
//   io_master_r{valid,ready,data,resp,last}
// ----------------------------------------------------------------------------
module axi_master_arbiter
    import ysyx_25040129_axi_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_resp_data,
    output logic                  ifu_resp_last,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_req_wen,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wstrb,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_resp_data,
    output logic                  lsu_resp_err,

    output logic                  io_master_awvalid,
    input  logic                  io_master_awready,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic [3:0]            io_master_awid,
    output logic [7:0]            io_master_awlen,
    output logic [2:0]            io_master_awsize,
    output logic [1:0]            io_master_awburst,

    output logic                  io_master_wvalid,
    input  logic                  io_master_wready,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    output logic                  io_master_wlast,

    input  logic                  io_master_bvalid,
    output logic                  io_master_bready,
    input  logic [1:0]            io_master_bresp,

    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [ADDR_W-1:0]     io_master_araddr,
    output logic [3:0]            io_master_arid,
    output logic [7:0]            io_master_arlen,
    output logic [2:0]            io_master_arsize,
    output logic [1:0]            io_master_arburst,

    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic [1:0]            io_master_rresp,
    input  logic                  io_master_rlast
);

    localparam int BEAT_W = $clog2(BURST_LEN) + 1;

    // IFU fills are aligned to the start of the BURST_LEN-word line.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(BURST_LEN * 4 - 1);
    endfunction

    axi_state_e              state_q, state_d;
    owner_e                  owner_q, owner_d;
    owner_e                  last_grant_q, last_grant_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;

    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W/8-1:0]     wstrb_q;

    logic [1:0]              grant;
    logic                    grant_any;
    logic                    aw_fire;
    logic                    w_fire;
    logic                    in_r;
    logic                    in_b;

    axi_rr_arbiter u_arb (
        .en_i         (state_q == ST_IDLE),
        .req_ifu_i    (ifu_req_valid),
        .req_lsu_i    (lsu_req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign grant_any = |grant;

    // Request ready is the grant itself: high only in the IDLE cycle that
    // accepts the request, so it is naturally a one-cycle pulse.
    assign ifu_req_ready = grant[GNT_IFU];
    assign lsu_req_ready = grant[GNT_LSU];

    // ---------------- control registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            beat_q       <= beat_d;
        end
    end

    // ---------------- request payload capture ----------------
    always_ff @(posedge clock) begin
        if (grant[GNT_LSU]) begin
            addr_q  <= lsu_req_addr;
            wdata_q <= lsu_req_wdata;
            wstrb_q <= lsu_req_wstrb;
        end else if (grant[GNT_IFU]) begin
            addr_q  <= ifu_req_addr;
        end
    end

    assign aw_fire = io_master_awvalid & io_master_awready;
    assign w_fire  = io_master_wvalid & io_master_wready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        beat_d       = beat_q;
        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                beat_d    = '0;
                if (grant_any) begin
                    if (grant[GNT_LSU]) begin
                        owner_d      = OWN_LSU;
                        last_grant_d = OWN_LSU;
                        state_d      = lsu_req_wen ? ST_AW_W : ST_AR;
                    end else begin
                        owner_d      = OWN_IFU;
                        last_grant_d = OWN_IFU;
                        state_d      = ST_AR;
                    end
                end
            end
            ST_AR: begin
                if (io_master_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (io_master_rvalid) begin
                    beat_d = beat_q + 1'b1;
                    if (io_master_rlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_AW_W: begin
                // Address and data handshakes complete independently.
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (io_master_bvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- AXI channel outputs ----------------
    assign io_master_arvalid = (state_q == ST_AR);
    assign io_master_araddr  = (owner_q == OWN_IFU) ? line_base(addr_q) : addr_q;
    assign io_master_arlen   = (owner_q == OWN_IFU) ? 8'(BURST_LEN - 1) : 8'd0;
    assign io_master_arid    = 4'd0;
    assign io_master_arsize  = SIZE_4B;
    assign io_master_arburst = BURST_INCR;

    assign io_master_awvalid = (state_q == ST_AW_W) && !aw_done_q;
    assign io_master_awaddr  = addr_q;
    assign io_master_awid    = 4'd0;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = SIZE_4B;
    assign io_master_awburst = BURST_INCR;

    assign io_master_wvalid  = (state_q == ST_AW_W) && !w_done_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = io_master_wvalid;

    assign io_master_bready  = (state_q == ST_B);
    assign io_master_rready  = (state_q == ST_R);

    // ---------------- response routing ----------------
    assign in_r = (state_q == ST_R) && io_master_rvalid;
    assign in_b = (state_q == ST_B) && io_master_bvalid;

    // IFU sees every beat unconditionally; rresp is not reported to it.
    assign ifu_resp_valid = in_r && (owner_q == OWN_IFU);
    assign ifu_resp_data  = io_master_rdata;
    assign ifu_resp_last  = ifu_resp_valid && io_master_rlast;

    assign lsu_resp_valid = (in_r && (owner_q == OWN_LSU)) || in_b;
    assign lsu_resp_data  = (state_q == ST_R) ? io_master_rdata : '0;

    // An LSU read is a single beat, so rlast anywhere but beat 0 is a
    // protocol error reported alongside a non-OKAY rresp.
    always_comb begin
        lsu_resp_err = 1'b0;
        if (state_q == ST_R) begin
            lsu_resp_err = (io_master_rresp != RESP_OKAY) ||
                           (io_master_rlast && (beat_q != '0));
        end else if (state_q == ST_B) begin
            lsu_resp_err = (io_master_bresp != RESP_OKAY);
        end
    end

endmodule

// File: tb/tb_axi_master_arbiter.sv
module tb_axi_master_arbiter;
    import ysyx_25040129_axi_pkg::*;

`ifdef YSYX_25040129_AXI_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid, ifu_resp_last;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_resp_valid, lsu_resp_err;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awid, arid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        arvalid, arready, rvalid, rready, rlast;

    int checks = 0;
    int errors = 0;

    axi_master_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_data(ifu_resp_data), .ifu_resp_last(ifu_resp_last),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .lsu_resp_err(lsu_resp_err),
        .io_master_awvalid(awvalid), .io_master_awready(awready),
        .io_master_awaddr(awaddr), .io_master_awid(awid), .io_master_awlen(awlen),
        .io_master_awsize(awsize), .io_master_awburst(awburst),
        .io_master_wvalid(wvalid), .io_master_wready(wready),
        .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp),
        .io_master_arvalid(arvalid), .io_master_arready(arready),
        .io_master_araddr(araddr), .io_master_arid(arid), .io_master_arlen(arlen),
        .io_master_arsize(arsize), .io_master_arburst(arburst),
        .io_master_rvalid(rvalid), .io_master_rready(rready),
        .io_master_rdata(rdata), .io_master_rresp(rresp), .io_master_rlast(rlast)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 0;
        lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0;
        lsu_req_wdata = 0; lsu_req_wstrb = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;

        // Reset state
        #2;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_ifu_ready", ifu_req_ready, 0);
        chk("rst_lsu_ready", lsu_req_ready, 0);
        chk("rst_lsu_resp", lsu_resp_valid, 0);
        chk("rst_state", dut.state_q, ST_IDLE);
        tick();
        reset = 1'b0;

        // IFU line fill
        tick();
        ifu_req_valid = 1; ifu_req_addr = 32'h3000_0014;
        #1;
        chk("fill_ifu_ready", ifu_req_ready, 1);
        chk("fill_lsu_ready", lsu_req_ready, 0);
        tick();
        ifu_req_valid = 0;
        #1;
        chk("fill_ifu_ready_pulse", ifu_req_ready, 0);
        chk("fill_arvalid", arvalid, 1);
        chk("fill_araddr", araddr, 32'h3000_0010);
        chk("fill_arlen", arlen, 3);
        chk("fill_arsize", arsize, 3'b010);
        chk("fill_arburst", arburst, 2'b01);
        arready = 1;
        tick();
        arready = 0;
        #1;
        chk("fill_arvalid_drop", arvalid, 0);
        chk("fill_rready", rready, 1);
        for (int i = 0; i < 4; i++) begin
            rvalid = 1; rdata = 32'hA0 + i; rlast = (i == 3); rresp = 0;
            #1;
            chk("fill_beat_valid", ifu_resp_valid, 1);
            chk("fill_beat_data", ifu_resp_data, 32'hA0 + i);
            chk("fill_beat_last", ifu_resp_last, (i == 3));
            chk("fill_beat_lsu", lsu_resp_valid, 0);
            tick();
        end
        rvalid = 0; rlast = 0;
        #1;
        chk("fill_idle", dut.state_q, ST_IDLE);
        chk("fill_rready_drop", rready, 0);

        // LSU store with wready 3 cycles after awready
        lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h1000_0000;
        lsu_req_wdata = 32'h41; lsu_req_wstrb = 4'b0001;
        #1;
        chk("st_lsu_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0; lsu_req_wen = 0;
        #1;
        chk("st_awvalid", awvalid, 1);
        chk("st_wvalid", wvalid, 1);
        chk("st_awaddr", awaddr, 32'h1000_0000);
        chk("st_awlen", awlen, 0);
        chk("st_wdata", wdata, 32'h41);
        chk("st_wstrb", wstrb, 4'b0001);
        chk("st_wlast", wlast, 1);
        awready = 1;
        tick();
        awready = 0;
        #1;
        chk("st_awvalid_drop", awvalid, 0);
        chk("st_wvalid_hold1", wvalid, 1);
        tick();
        tick();
        chk("st_wvalid_hold2", wvalid, 1);
        chk("st_bready_early", bready, 0);
        wready = 1;
        tick();
        wready = 0;
        #1;
        chk("st_wvalid_drop", wvalid, 0);
        chk("st_bready", bready, 1);
        bvalid = 1; bresp = 0;
        #1;
        chk("st_resp_valid", lsu_resp_valid, 1);
        chk("st_resp_err", lsu_resp_err, 0);
        chk("st_resp_data", lsu_resp_data, 0);
        tick();
        bvalid = 0;
        #1;
        chk("st_resp_pulse", lsu_resp_valid, 0);
        chk("st_idle", dut.state_q, ST_IDLE);

        // Reset pulse so the arbitration history starts fresh
        reset = 1;
        tick();
        reset = 0;

        // Tie #1: LSU read vs IFU fill
        ifu_req_valid = 1; ifu_req_addr = 32'h3000_0000;
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h2000_0000;
        #1;
        chk("tie1_lsu_ready", lsu_req_ready, 1);
        chk("tie1_ifu_ready", ifu_req_ready, 0);
        tick();
        lsu_req_valid = 0;
        #1;
        chk("tie1_araddr", araddr, 32'h2000_0000);
        chk("tie1_arlen", arlen, 0);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rlast = 1; rdata = 32'h55; rresp = 0;
        #1;
        chk("tie1_lsu_resp", lsu_resp_valid, 1);
        chk("tie1_lsu_data", lsu_resp_data, 32'h55);
        chk("tie1_lsu_err", lsu_resp_err, 0);
        chk("tie1_ifu_resp", ifu_resp_valid, 0);
        tick();
        rvalid = 0; rlast = 0;

        // Tie #2
        lsu_req_valid = 1; lsu_req_addr = 32'h2000_0004;
        #1;
        chk("tie2_lsu_ready", lsu_req_ready, !RR);
        chk("tie2_ifu_ready", ifu_req_ready, RR);
        tick();
        lsu_req_valid = 0; ifu_req_valid = 0;
        #1;
        chk("tie2_araddr", araddr, RR ? 32'h3000_0000 : 32'h2000_0004);
        chk("tie2_arlen", arlen, RR ? 3 : 0);
        arready = 1;
        tick();
        arready = 0;
        for (int i = 0; i < (RR ? 4 : 1); i++) begin
            rvalid = 1; rdata = 32'h60 + i; rlast = (i == (RR ? 3 : 0));
            #1;
            chk("tie2_beat", RR ? ifu_resp_valid : lsu_resp_valid, 1);
            tick();
        end
        rvalid = 0; rlast = 0;
        #1;
        chk("tie2_idle", dut.state_q, ST_IDLE);
        chk("tie2_no_regrant", ifu_req_ready | lsu_req_ready, 0);

        // LSU read with SLVERR
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_0000;
        tick();
        lsu_req_valid = 0;
        #1;
        chk("err_araddr", araddr, 32'h8000_0000);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rlast = 1; rresp = 2'b10; rdata = 32'hDEAD;
        #1;
        chk("err_resp_valid", lsu_resp_valid, 1);
        chk("err_resp_err", lsu_resp_err, 1);
        tick();
        rvalid = 0; rlast = 0; rresp = 0;

        // IFU burst terminated early by rlast on beat 2
        ifu_req_valid = 1; ifu_req_addr = 32'h3000_0040;
        tick();
        ifu_req_valid = 0;
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rlast = 0; rdata = 32'h1;
        #1;
        chk("early_b1_last", ifu_resp_last, 0);
        tick();
        rlast = 1; rdata = 32'h2; rresp = 2'b10;
        #1;
        chk("early_b2_valid", ifu_resp_valid, 1);
        chk("early_b2_last", ifu_resp_last, 1);
        tick();
        rvalid = 0; rlast = 0; rresp = 0;
        #1;
        chk("early_idle", dut.state_q, ST_IDLE);
        chk("early_rready", rready, 0);

        // Reset in the middle of a burst
        ifu_req_valid = 1; ifu_req_addr = 32'h3000_0080;
        tick();
        ifu_req_valid = 0;
        #1;
        chk("mid_arvalid", arvalid, 1);
        arready = 1;
        tick();
        arready = 0;
        for (int i = 0; i < 2; i++) begin
            rvalid = 1; rlast = 0; rdata = 32'h70 + i;
            tick();
        end
        rvalid = 1; rdata = 32'h72;
        reset = 1;
        #1;
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_ifu_resp", ifu_resp_valid, 0);
        tick();
        reset = 0; rvalid = 0;
        ifu_req_valid = 1; ifu_req_addr = 32'h3000_0004;
        #1;
        chk("post_ifu_ready", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0;
        #1;
        chk("post_araddr", araddr, 32'h3000_0000);
        chk("post_arlen", arlen, 3);
        arready = 1;
        tick();
        arready = 0;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1; rdata = 32'hB0 + i; rlast = (i == 3);
            #1;
            chk("post_beat_data", ifu_resp_data, 32'hB0 + i);
            chk("post_beat_last", ifu_resp_last, (i == 3));
            tick();
        end
        rvalid = 0; rlast = 0;
        #1;
        chk("post_idle", dut.state_q, ST_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
